ccr_unit: RTL and testbench

Condition-code register for the execute-memory stage. Holds the Z/N/C flags, feeds them back to the ALU flag inputs, and loads the ALU's flag outputs when an instruction writes flags. Also applies SETC/CLRC, evaluates and consumes conditional-jump flags, and saves/restores flags across interrupt entry and return (INT/RTI) with a small hardware stack.

---
 rtl/ccr_unit.sv | 168 ++++++++++++++++
 tb/tb_ccr_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register for the execute-memory stage.
// Holds the Z/N/C flags fed back to the ALU, loads ALU flag results, applies
// SETC/CLRC, consumes the flag tested by a taken conditional jump, and
// saves/restores flags across interrupt entry/RTI on a small hardware stack.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), synchronous active-low reset
//   i_stall                 freezes all state
//   i_alu_we, i_alu_*       ALU flag write enable and flag values
//   i_setc, i_clrc          set / clear carry
//   i_br_valid, i_br_cond   branch present; 00 JZ, 01 JN, 10 JC, 11 JMP
//   i_int_save              push current flags
//   i_rti_restore           pop flags
//   o_*_flag                registered flags
//   o_br_taken              combinational branch decision from registered flags
//   o_depth                 number of saved flag sets
//   o_overflow/o_underflow  sticky stack error flags
module ccr_unit #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_stall,
  input  logic                               i_alu_we,
  input  logic                               i_alu_zero,
  input  logic                               i_alu_negative,
  input  logic                               i_alu_carry,
  input  logic                               i_setc,
  input  logic                               i_clrc,
  input  logic                               i_br_valid,
  input  logic [1:0]                         i_br_cond,
  input  logic                               i_int_save,
  input  logic                               i_rti_restore,
  output logic                               o_zero_flag,
  output logic                               o_negative_flag,
  output logic                               o_carry_flag,
  output logic                               o_br_taken,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_depth,
  output logic                               o_overflow,
  output logic                               o_underflow
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] MAX_DEPTH = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    COND_JZ  = 2'b00,
    COND_JN  = 2'b01,
    COND_JC  = 2'b10,
    COND_JMP = 2'b11
  } br_cond_e;

  // Flag vector layout: [2] Z, [1] N, [0] C
  logic [2:0]    flags_q, flags_d;
  logic [2:0]    stack_q [STACK_DEPTH];
  logic [2:0]    stack_d [STACK_DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  br_cond_e cond;
  logic     push_only;
  logic     pop_only;

  assign cond      = br_cond_e'(i_br_cond);
  assign push_only = i_int_save & ~i_rti_restore;
  assign pop_only  = i_rti_restore & ~i_int_save;

  always_comb begin
    o_br_taken = 1'b0;
    if (i_br_valid) begin
      unique case (cond)
        COND_JZ:  o_br_taken = flags_q[2];
        COND_JN:  o_br_taken = flags_q[1];
        COND_JC:  o_br_taken = flags_q[0];
        COND_JMP: o_br_taken = 1'b1;
        default:  o_br_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    flags_d = flags_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
    end

    if (i_alu_we) begin
      flags_d = {i_alu_zero, i_alu_negative, i_alu_carry};
    end

    if (i_setc & ~i_clrc) begin
      flags_d[0] = 1'b1;
    end else if (i_clrc & ~i_setc) begin
      flags_d[0] = 1'b0;
    end

    // A taken conditional jump consumes the flag it tested.
    if (o_br_taken) begin
      unique case (cond)
        COND_JZ:  flags_d[2] = 1'b0;
        COND_JN:  flags_d[1] = 1'b0;
        COND_JC:  flags_d[0] = 1'b0;
        default:  ;
      endcase
    end

    if (push_only) begin
      if (depth_q < MAX_DEPTH) begin
        // Stack slot is selected by loop compare to keep index widths exact
        // for any STACK_DEPTH.
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
          if (DW'(i) == depth_q) begin
            stack_d[i] = flags_q;
          end
        end
        depth_d = depth_q + DW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop_only) begin
      if (depth_q != '0) begin
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
          if (DW'(i + 1) == depth_q) begin
            flags_d = stack_q[i];
          end
        end
        depth_d = depth_q - DW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      flags_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!i_stall) begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is not reset; entries above o_depth are never read.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_stall) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign o_zero_flag     = flags_q[2];
  assign o_negative_flag = flags_q[1];
  assign o_carry_flag    = flags_q[0];
  assign o_depth         = depth_q;
  assign o_overflow      = ovf_q;
  assign o_underflow     = unf_q;

endmodule

// File: tb/tb_ccr_unit.sv
module tb_ccr_unit;

  localparam int unsigned D  = 4;
  localparam int unsigned DW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n, stall, alu_we, alu_z, alu_n, alu_c;
  logic          setc, clrc, br_valid, save, rest;
  logic [1:0]    br_cond;
  logic          z_f, n_f, c_f, br_taken, ovf, unf;
  logic [DW-1:0] depth;

  int checks   = 0;
  int failures = 0;

  // Behavioural model
  logic [2:0] mf;
  logic [2:0] mstack[$];
  logic       movf, munf;

  ccr_unit #(.STACK_DEPTH(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
    .i_alu_we(alu_we), .i_alu_zero(alu_z), .i_alu_negative(alu_n), .i_alu_carry(alu_c),
    .i_setc(setc), .i_clrc(clrc), .i_br_valid(br_valid), .i_br_cond(br_cond),
    .i_int_save(save), .i_rti_restore(rest),
    .o_zero_flag(z_f), .o_negative_flag(n_f), .o_carry_flag(c_f),
    .o_br_taken(br_taken), .o_depth(depth), .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  function automatic logic exp_taken();
    if (!br_valid) return 1'b0;
    if (br_cond == 2'b11) return 1'b1;
    return mf[2 - br_cond];
  endfunction

  function automatic logic [DW+4:0] exp_vec();
    return {mf, DW'(mstack.size()), movf, munf};
  endfunction

  function automatic logic [DW+4:0] obs_vec();
    return {z_f, n_f, c_f, depth, ovf, unf};
  endfunction

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; alu_we = 1'b0; alu_z = 1'b0; alu_n = 1'b0; alu_c = 1'b0;
    setc = 1'b0; clrc = 1'b0; br_valid = 1'b0; br_cond = 2'b00; save = 1'b0; rest = 1'b0;
  endtask

  // Advance one clock and apply the specification's update rules to the model.
  task automatic step();
    logic [2:0] nf;
    logic       tk;
    @(posedge clk);
    tk = exp_taken();
    if (!rst_n) begin
      mf = 3'b000; mstack.delete(); movf = 1'b0; munf = 1'b0;
    end else if (!stall) begin
      nf = mf;
      if (alu_we) nf = {alu_z, alu_n, alu_c};
      if (setc != clrc) nf[0] = setc;
      if (tk && br_cond != 2'b11) nf[2 - br_cond] = 1'b0;
      if (save && !rest) begin
        if (mstack.size() < D) mstack.push_back(mf);
        else movf = 1'b1;
      end else if (rest && !save) begin
        if (mstack.size() > 0) nf = mstack.pop_back();
        else munf = 1'b1;
      end
      mf = nf;
    end
    #1;
    idle();
    #1;
  endtask

  task automatic alu_write(input logic [2:0] f);
    alu_we = 1'b1; {alu_z, alu_n, alu_c} = f;
    step();
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b0; alu_we = 1'b1; {alu_z, alu_n, alu_c} = 3'b111; save = 1'b1;
    step();
    checks++;
    if (obs_vec() !== '0 || br_taken !== 1'b0) begin
      failures++; $display("FAIL reset: got %b/%b expected 0", obs_vec(), br_taken);
    end
    alu_write(3'b101);
    checks++;
    if ({z_f, n_f, c_f} !== 3'b101) begin
      failures++; $display("FAIL alu_write: got %b expected 101", {z_f, n_f, c_f});
    end
  endtask

  task automatic test_setc_clrc();
    logic [3:0] exp_c;
    exp_c = 4'b1101;
    alu_write(3'b000);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: setc = 1'b1;
        1: begin setc = 1'b1; clrc = 1'b1; end
        2: clrc = 1'b1;
        default: begin alu_we = 1'b1; {alu_z, alu_n, alu_c} = 3'b000; setc = 1'b1; end
      endcase
      step();
      checks++;
      if (c_f !== exp_c[3 - k] || obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL setc_clrc[%0d]: got C=%b expected C=%b", k, c_f, exp_c[3 - k]);
      end
    end
  endtask

  task automatic test_branch();
    logic [1:0] conds [4];
    logic       takes [4];
    logic [2:0] flg   [4];
    conds = '{2'b00, 2'b01, 2'b00, 2'b11};
    takes = '{1'b1, 1'b1, 1'b0, 1'b1};
    flg   = '{3'b011, 3'b001, 3'b001, 3'b001};
    alu_write(3'b111);
    for (int k = 0; k < 4; k++) begin
      br_valid = 1'b1; br_cond = conds[k];
      #1;
      checks++;
      if (br_taken !== takes[k]) begin
        failures++; $display("FAIL branch_taken[%0d]: got %b expected %b", k, br_taken, takes[k]);
      end
      step();
      checks++;
      if ({z_f, n_f, c_f} !== flg[k]) begin
        failures++; $display("FAIL branch_flags[%0d]: got %b expected %b", k, {z_f, n_f, c_f}, flg[k]);
      end
    end
  endtask

  task automatic test_nesting();
    alu_write(3'b010);
    save = 1'b1; step();
    checks++;
    if (depth !== DW'(1)) begin failures++; $display("FAIL nest_push1: got depth %0d expected 1", depth); end
    alu_write(3'b100);
    save = 1'b1; step();
    checks++;
    if (depth !== DW'(2)) begin failures++; $display("FAIL nest_push2: got depth %0d expected 2", depth); end
    alu_write(3'b001);
    rest = 1'b1; step();
    checks++;
    if ({z_f, n_f, c_f} !== 3'b100 || depth !== DW'(1)) begin
      failures++; $display("FAIL nest_pop1: got %b/%0d expected 100/1", {z_f, n_f, c_f}, depth);
    end
    rest = 1'b1; step();
    checks++;
    if ({z_f, n_f, c_f} !== 3'b010 || depth !== DW'(0)) begin
      failures++; $display("FAIL nest_pop2: got %b/%0d expected 010/0", {z_f, n_f, c_f}, depth);
    end
  endtask

  task automatic test_limits();
    rst_n = 1'b0; step();
    for (int k = 0; k < 5; k++) begin
      save = 1'b1; step();
      checks++;
      if (ovf !== (k == 4) || depth !== DW'((k < 4) ? k + 1 : 4)) begin
        failures++; $display("FAIL overflow[%0d]: got depth %0d ovf %b", k, depth, ovf);
      end
    end
    rst_n = 1'b0; step();
    rest = 1'b1; step();
    checks++;
    if (unf !== 1'b1 || {z_f, n_f, c_f} !== 3'b000 || depth !== DW'(0)) begin
      failures++; $display("FAIL underflow: got unf %b flags %b expected 1/000", unf, {z_f, n_f, c_f});
    end
    step();
    checks++;
    if (unf !== 1'b1) begin failures++; $display("FAIL underflow_sticky: got %b expected 1", unf); end
  endtask

  task automatic test_stall_reset();
    rst_n = 1'b0; step();
    alu_write(3'b110);
    stall = 1'b1; alu_we = 1'b1; {alu_z, alu_n, alu_c} = 3'b001; save = 1'b1; setc = 1'b1;
    step();
    checks++;
    if (obs_vec() !== {3'b110, DW'(0), 2'b00}) begin
      failures++; $display("FAIL stall: got %b expected frozen", obs_vec());
    end
    save = 1'b1; step();
    save = 1'b1; step();
    checks++;
    if (depth !== DW'(2)) begin failures++; $display("FAIL stall_push: got %0d expected 2", depth); end
    rst_n = 1'b0; stall = 1'b1; step();
    checks++;
    if (depth !== DW'(0) || {z_f, n_f, c_f} !== 3'b000) begin
      failures++; $display("FAIL midop_reset: got %0d/%b expected 0/000", depth, {z_f, n_f, c_f});
    end
    rest = 1'b1; step();
    checks++;
    if (unf !== 1'b1) begin failures++; $display("FAIL reset_then_pop: got %b expected 1", unf); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst_n    = ($urandom_range(0, 39) != 0);
      stall    = ($urandom_range(0, 5) == 0);
      alu_we   = $urandom_range(0, 1);
      {alu_z, alu_n, alu_c} = 3'($urandom);
      setc     = ($urandom_range(0, 3) == 0);
      clrc     = ($urandom_range(0, 3) == 0);
      br_valid = $urandom_range(0, 1);
      br_cond  = 2'($urandom);
      save     = ($urandom_range(0, 2) == 0);
      rest     = ($urandom_range(0, 2) == 0);
      #1;
      checks++;
      if (br_taken !== exp_taken()) begin
        failures++; $display("FAIL rand_taken[%0d]: got %b expected %b", k, br_taken, exp_taken());
      end
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL rand_state[%0d]: got %b expected %b", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    mf = 3'b000; movf = 1'b0; munf = 1'b0;
    idle();
    #2;
    test_reset();
    test_setc_clrc();
    test_branch();
    test_nesting();
    test_limits();
    test_stall_reset();
    rst_n = 1'b0; step();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
